// File: rtl/softmax_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : softmax_pkg
//  Purpose  : Shared types and constants for the softmax accumulator
//             sequencer: FSM state encoding and IEEE-754 single constants.
//  Revision : 1.0  initial release
// ============================================================================
package softmax_pkg;

    // Sequencer states, three bits wide
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        ISSUE   = 3'd2,
        WAIT    = 3'd3,
        SETTLE  = 3'd4,
        CAPTURE = 3'd5
    } state_t;

    // +0.0 doubles as the "no data" bubble for the accumulator
    localparam logic [31:0] FP_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP_ONE  = 32'h3F80_0000;

endpackage
`default_nettype wire

// File: rtl/rd_valid_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : rd_valid_pipe
//  Purpose  : RD_LAT-deep shift register that tracks buffer reads in flight.
//             valid_out marks the cycle the read data is on mem_rdata;
//             valid_next shows what valid_out will be one cycle later so the
//             sequencer can plan the cycle in which the final element lands.
//  Revision : 1.0  initial release
// ============================================================================
module rd_valid_pipe #(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic valid_in,
    output logic valid_out,
    output logic valid_next
);

    logic [RD_LAT-1:0] stage;

    generate
        if (RD_LAT == 1) begin : g_single
            // Single stage: the request itself is next cycle's valid
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    stage <= '0;
                end else begin
                    stage <= valid_in;
                end
            end
            assign valid_next = valid_in;
        end else begin : g_multi
            // Shift the read request down the pipe one stage per cycle
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    stage <= '0;
                end else begin
                    stage <= {stage[RD_LAT-2:0], valid_in};
                end
            end
            assign valid_next = stage[RD_LAT-2];
        end
    endgenerate

    assign valid_out = stage[RD_LAT-1];

endmodule
`default_nettype wire

// File: rtl/softmax_accum_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : softmax_accum_ctrl
//  Purpose  : Sequencer for the softmax floating-point accumulator. On start
//             it clears the accumulator, streams len single-precision values
//             from the exponent buffer into it, hides the buffer read latency
//             and captures the final sum for the normalisation stage.
//  Revision : 1.0  initial release
// ============================================================================
module softmax_accum_ctrl
    import softmax_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 9,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic [31:0]       sum_out,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    output logic              acc_start,
    output logic [31:0]       acc_in,
    input  logic [31:0]       acc_r
);

    state_t            state;
    logic [CNT_W-1:0]  len_q;
    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  issued;     // reads issued, including the one on mem_ren now
    logic [CNT_W-1:0]  received;   // elements already handed to the accumulator
    logic              zero_len;   // current command had len == 0

    logic              valid_out;
    logic              valid_next;
    logic [CNT_W:0]    delivered_next;
    logic              last_next;
    logic              all_issued;
    logic [ADDR_W-1:0] next_addr;

    rd_valid_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_valid_pipe (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (mem_ren),
        .valid_out  (valid_out),
        .valid_next (valid_next)
    );

    // Read data only reaches the accumulator when the pipe says it is real;
    // otherwise a +0 bubble keeps the running sum unchanged.
    assign acc_in = valid_out ? mem_rdata : FP_ZERO;

    // Elements handed over by the end of next cycle; when that reaches len
    // with an element arriving next cycle, next cycle carries the last one.
    assign delivered_next = {1'b0, received}
                          + {{CNT_W{1'b0}}, valid_out}
                          + {{CNT_W{1'b0}}, valid_next};
    assign last_next      = valid_next && (delivered_next == {1'b0, len_q});
    assign all_issued     = (issued == len_q);
    assign next_addr      = base_q + ADDR_W'(issued);

    // Sequencer: command acceptance, read issue, drain and sum capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum_out   <= FP_ZERO;
            mem_ren   <= 1'b0;
            mem_addr  <= '0;
            acc_start <= 1'b0;
            len_q     <= '0;
            base_q    <= '0;
            issued    <= '0;
            received  <= '0;
            zero_len  <= 1'b0;
        end else begin
            done <= 1'b0;

            if (valid_out && (state != IDLE)) begin
                received <= received + CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        busy     <= 1'b1;
                        len_q    <= len;
                        base_q   <= base_addr;
                        received <= '0;
                        if (len != '0) begin
                            // First read goes out together with the clear
                            state     <= CLEAR;
                            acc_start <= 1'b1;
                            mem_ren   <= 1'b1;
                            mem_addr  <= base_addr;
                            issued    <= CNT_W'(1);
                            zero_len  <= 1'b0;
                        end else begin
                            state    <= CAPTURE;
                            issued   <= '0;
                            zero_len <= 1'b1;
                        end
                    end
                end

                CLEAR, ISSUE: begin
                    acc_start <= 1'b0;
                    if (last_next) begin
                        // Short latency: the final element lands next cycle
                        state   <= SETTLE;
                        mem_ren <= 1'b0;
                    end else if (all_issued) begin
                        state   <= WAIT;
                        mem_ren <= 1'b0;
                    end else begin
                        state    <= ISSUE;
                        mem_ren  <= 1'b1;
                        mem_addr <= next_addr;
                        issued   <= issued + CNT_W'(1);
                    end
                end

                WAIT: begin
                    if (last_next) begin
                        state <= SETTLE;
                    end
                end

                SETTLE: begin
                    // Final element is on acc_in; the accumulator absorbs it
                    state <= CAPTURE;
                end

                CAPTURE: begin
                    sum_out <= zero_len ? FP_ZERO : acc_r;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_softmax_accum_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_softmax_accum_ctrl
//  Purpose  : Scoreboard bench for softmax_accum_ctrl. Two instances (read
//             latency 1 and 3) share one command stream; each has its own
//             buffer read pipe and behavioural FP accumulator.
//  Revision : 1.0  initial release
// ============================================================================
module tb_softmax_accum_ctrl;

    localparam int NI     = 2;
    localparam int ADDR_W = 8;
    localparam int CNT_W  = 9;
    localparam int LAT0   = 1;
    localparam int LAT1   = 3;

    typedef struct {
        int          s;     // cycle in which start was sampled
        int          n;
        int          base;
        logic [31:0] sum;
    } txn_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [CNT_W-1:0]  len = '0;
    logic [ADDR_W-1:0] base_addr = '0;

    logic              busy      [NI];
    logic              done      [NI];
    logic [31:0]       sum_out   [NI];
    logic              mem_ren   [NI];
    logic [ADDR_W-1:0] mem_addr  [NI];
    logic [31:0]       mem_rdata [NI];
    logic              acc_start [NI];
    logic [31:0]       acc_in    [NI];
    logic [31:0]       acc_r     [NI];

    logic [31:0] mem [256];
    txn_t        sbq [NI][$];
    int          free_at [NI];
    logic [31:0] held [NI];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- FP helpers (plain real arithmetic) ----------------
    function automatic real p2(input int e);
        real r = 1.0;
        if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
        else        for (int i = 0; i < -e; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic real fp2r(input logic [31:0] b);
        real m;
        int  e;
        e = int'(b[30:23]);
        if (e == 0)        m = real'(b[22:0]) * p2(-149);
        else if (e == 255) m = 0.0;
        else               m = (1.0 + real'(b[22:0]) * p2(-23)) * p2(e - 127);
        return b[31] ? -m : m;
    endfunction

    function automatic logic [31:0] r2fp(input real x);
        real  a;
        int   e = 0;
        int   mant;
        logic s;
        if (x == 0.0) return 32'h0;
        s = (x < 0.0);
        a = s ? -x : x;
        while (a >= 2.0 && e < 120)  begin a = a / 2.0; e++; end
        while (a < 1.0  && e > -120) begin a = a * 2.0; e--; end
        mant = $rtoi((a - 1.0) * 8388608.0 + 0.5);
        if (mant >= 8388608) begin mant = 0; e++; end
        return {s, 8'(e + 127), mant[22:0]};
    endfunction

    function automatic logic [31:0] rand_val();
        int q;
        q = int'($urandom_range(0, 128)) - 64;
        return r2fp(real'(q) * 0.25);
    endfunction

    function automatic logic [31:0] exp_sum(input int n, input int ba);
        real acc = 0.0;
        for (int i = 0; i < n; i++) acc = acc + fp2r(mem[(ba + i) & 255]);
        return r2fp(acc);
    endfunction

    function automatic int lat_of(input int k);
        return (k == 0) ? LAT0 : LAT1;
    endfunction

    // ---------------- DUTs with buffer and accumulator models ----------------
    for (genvar k = 0; k < NI; k++) begin : g_inst
        localparam int L = (k == 0) ? LAT0 : LAT1;
        logic [31:0] rd_pipe [L];
        logic [31:0] acc_q;

        softmax_accum_ctrl #(
            .ADDR_W (ADDR_W),
            .CNT_W  (CNT_W),
            .RD_LAT (L)
        ) dut (
            .clk       (clk),
            .rst       (rst),
            .start     (start),
            .len       (len),
            .base_addr (base_addr),
            .busy      (busy[k]),
            .done      (done[k]),
            .sum_out   (sum_out[k]),
            .mem_ren   (mem_ren[k]),
            .mem_addr  (mem_addr[k]),
            .mem_rdata (mem_rdata[k]),
            .acc_start (acc_start[k]),
            .acc_in    (acc_in[k]),
            .acc_r     (acc_r[k])
        );

        // Buffer with L-cycle read latency; junk on the bus when not reading
        always @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < L; i++) rd_pipe[i] <= '0;
            end else begin
                rd_pipe[0] <= mem_ren[k] ? mem[mem_addr[k]] : rand_val();
                for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
            end
        end
        assign mem_rdata[k] = rd_pipe[L-1];

        // Accumulator: clear on start_FC, hold on +/-0, otherwise add
        always @(posedge clk or posedge rst) begin
            if (rst)                          acc_q <= '0;
            else if (acc_start[k])            acc_q <= '0;
            else if (acc_in[k][30:0] != '0)   acc_q <= r2fp(fp2r(acc_q) + fp2r(acc_in[k]));
        end
        assign acc_r[k] = acc_q;
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s inst%0d cyc=%0d: got %h expected %h", name, k, cyc, act, exp);
        end
    endtask

    // Monitor: compare every cycle against the head transaction of each scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < NI; k++) begin
                txn_t        t;
                int          j;
                int          d;
                int          lk;
                logic        ren_e;
                logic [31:0] ain;
                lk = lat_of(k);
                if (sbq[k].size() > 0 && cyc > sbq[k][0].s) begin
                    t     = sbq[k][0];
                    j     = cyc - t.s;
                    d     = (t.n == 0) ? 2 : t.n + lk + 2;
                    ren_e = (t.n > 0) && (j >= 1) && (j <= t.n);
                    ain   = ((t.n > 0) && (j >= 1 + lk) && (j <= t.n + lk)) ?
                            mem[(t.base + j - 1 - lk) & 255] : 32'h0;
                    if (j == d) held[k] = t.sum;
                    chk("done", k, 32'(done[k]), 32'(j == d));
                    chk("busy", k, 32'(busy[k]), 32'(j < d));
                    chk("mem_ren", k, 32'(mem_ren[k]), 32'(ren_e));
                    if (ren_e) chk("mem_addr", k, 32'(mem_addr[k]), 32'((t.base + j - 1) & 255));
                    chk("acc_start", k, 32'(acc_start[k]), 32'((t.n > 0) && (j == 1)));
                    chk("acc_in", k, acc_in[k], ain);
                    if (j >= d) void'(sbq[k].pop_front());
                end else begin
                    chk("idle_done", k, 32'(done[k]), 32'h0);
                    chk("idle_busy", k, 32'(busy[k]), 32'h0);
                    chk("idle_ren", k, 32'(mem_ren[k]), 32'h0);
                    chk("idle_acc_start", k, 32'(acc_start[k]), 32'h0);
                    chk("idle_acc_in", k, acc_in[k], 32'h0);
                end
                chk("sum_out", k, sum_out[k], held[k]);
            end
        end
    end

    // ---------------- stimulus ----------------
    // One cycle of command inputs; acceptance follows the idle-window rule
    task automatic drive(input bit st, input int ln, input int ba);
        txn_t t;
        @(negedge clk);
        start     = st;
        len       = ln[CNT_W-1:0];
        base_addr = ba[ADDR_W-1:0];
        if (st) begin
            for (int k = 0; k < NI; k++) begin
                if (cyc >= free_at[k]) begin
                    t.s    = cyc;
                    t.n    = ln;
                    t.base = ba;
                    t.sum  = exp_sum(ln, ba);
                    sbq[k].push_back(t);
                    free_at[k] = cyc + ((ln == 0) ? 2 : ln + lat_of(k) + 2);
                end
            end
        end
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 2000; i++) begin
            if (sbq[0].size() == 0 && sbq[1].size() == 0 &&
                cyc >= free_at[0] && cyc >= free_at[1]) begin
                ok = 1;
                break;
            end
            drive(0, 0, 0);
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: pending %0d/%0d transactions, expected 0", sbq[0].size(), sbq[1].size());
        end
        drive(0, 0, 0);
    endtask

    task automatic check_reset_outputs();
        for (int k = 0; k < NI; k++) begin
            chk("rst_busy", k, 32'(busy[k]), 32'h0);
            chk("rst_done", k, 32'(done[k]), 32'h0);
            chk("rst_sum", k, sum_out[k], 32'h0);
            chk("rst_ren", k, 32'(mem_ren[k]), 32'h0);
            chk("rst_addr", k, 32'(mem_addr[k]), 32'h0);
            chk("rst_acc_start", k, 32'(acc_start[k]), 32'h0);
            chk("rst_acc_in", k, acc_in[k], 32'h0);
        end
    endtask

    // Assert reset mid-stream: outputs drop at once, pending work is abandoned
    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        #1;
        check_reset_outputs();
        for (int k = 0; k < NI; k++) begin
            sbq[k].delete();
            free_at[k] = 0;
            held[k]    = 32'h0;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = rand_val();
        for (int k = 0; k < NI; k++) begin
            free_at[k] = 0;
            held[k]    = 32'h0;
        end
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        drive(0, 0, 0);

        // Four known values at 0x10
        mem[8'h10] = r2fp(1.0); mem[8'h11] = r2fp(2.0);
        mem[8'h12] = r2fp(3.0); mem[8'h13] = r2fp(4.0);
        drive(1, 4, 'h10);
        wait_idle();

        // Empty command
        drive(1, 0, 'h33);
        wait_idle();

        // Fractions
        mem[8'h40] = r2fp(0.5); mem[8'h41] = r2fp(0.25);
        drive(1, 2, 'h40);
        wait_idle();

        // Address wrap
        drive(1, 3, 'hFE);
        wait_idle();

        // Reset during ISSUE, then a single-element run
        drive(1, 8, 'h80);
        drive(0, 0, 0);
        drive(0, 0, 0);
        do_reset();
        mem[8'h20] = r2fp(2.0);
        drive(1, 1, 'h20);
        wait_idle();

        // start held high: no re-accept while busy, accept again in done cycle
        mem[8'h50] = r2fp(3.0); mem[8'h51] = r2fp(-1.0);
        for (int i = 0; i < 8; i++) drive(1, 2, 'h50);
        drive(0, 0, 0);
        wait_idle();

        // Longest command with wrap
        drive(1, 511, 'hC0);
        wait_idle();

        // Random commands with random gaps
        for (int i = 0; i < 256; i++) mem[i] = rand_val();
        for (int it = 0; it < 40; it++) begin
            int ln;
            int gap;
            ln  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(20, 60)) : int'($urandom_range(0, 10));
            gap = int'($urandom_range(0, 12));
            drive(1, ln, int'($urandom_range(0, 255)));
            for (int g = 0; g < gap; g++) drive(0, 0, 0);
        end
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
